// File: rtl/soc_system_fma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_fma_ctrl
// Purpose  : Avalon-MM slave that sequences one external fused-multiply-add
//            datapath for the HPS. Software loads three 16-bit operands,
//            writes a start command, and later reads back status and result.
//            The controller pulses fma_start for one cycle, waits for
//            fma_done or a timeout, and captures the datapath result.
//
// Ports    : clk         system clock, rising edge
//            reset       asynchronous active-high reset
//            address     register word address (3 bits)
//            write       single-cycle write strobe
//            writedata   32-bit write data
//            readdata    registered read data (one-cycle latency, every cycle)
//            fma_a/b/c   operand registers to the datapath
//            fma_start   one-cycle start pulse to the datapath
//            fma_done    datapath completion (sampled only while waiting)
//            fma_result  datapath result, valid with fma_done
//            irq         interrupt (only when FMA_CTRL_IRQ_EN is defined)
//
// Register : 0 OPA  1 OPB  2 OPC  3 CTRL/STATUS  4 RESULT  5-7 read as 0
//            CTRL  write: bit0 start, bit1 clear done/timeout, bit2 irq_en
//            STATUS read: bit0 busy, bit1 done, bit2 timeout, bit3 irq_en
//
// Options  : FMA_CTRL_IRQ_EN - adds the irq port and the irq_en control bit.
//
// Revision : 1.0 - initial release
// ============================================================================
module soc_system_fma_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [15:0] fma_a,
  output logic [15:0] fma_b,
  output logic [15:0] fma_c,
  output logic        fma_start,
  input  logic        fma_done,
  input  logic [15:0] fma_result
`ifdef FMA_CTRL_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [15:0] c_cnt_last = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_busy;

  logic [15:0] r_opa;
  logic [15:0] r_opb;
  logic [15:0] r_opc;
  logic [15:0] r_result;
  logic [15:0] r_cnt;
  logic        r_done;
  logic        r_timeout;
  logic [31:0] r_readdata;
  logic        w_irq_en;

  logic        w_idle;
  logic        w_wr_ctrl;
  logic        w_start;
  logic        w_clear;
  logic        w_done_hit;
  logic        w_tmo_hit;
  logic        w_unused;

  // --------------------------------------------------------------------------
  // Write decode
  // --------------------------------------------------------------------------
  assign w_idle     = (r_state == S_IDLE);
  assign w_wr_ctrl  = write && (address == 3'd3);
  // A start while busy is silently dropped; only an idle FSM accepts it.
  assign w_start    = w_wr_ctrl && writedata[0] && w_idle;
  // An accepted start implicitly clears the previous done/timeout.
  assign w_clear    = (w_wr_ctrl && writedata[1]) || w_start;
  // fma_done outranks the timeout when both land on the same cycle.
  assign w_done_hit = (r_state == S_WAIT) && fma_done;
  assign w_tmo_hit  = (r_state == S_WAIT) && !fma_done && (r_cnt == c_cnt_last);

  // Upper write-data bits have no register behind them.
  assign w_unused   = &{1'b0, writedata[31:16]};

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    fma_start   = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        fma_start   = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (w_done_hit || w_tmo_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Wait-cycle counter: zeroed in ISSUE, counts WAIT cycles up to the limit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 16'd0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= 16'd0;
    end else if ((r_state == S_WAIT) && !w_done_hit && !w_tmo_hit) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Operand registers: frozen while the datapath is working on them.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_opa <= 16'd0;
      r_opb <= 16'd0;
      r_opc <= 16'd0;
    end else if (write && w_idle) begin
      if (address == 3'd0) r_opa <= writedata[15:0];
      if (address == 3'd1) r_opb <= writedata[15:0];
      if (address == 3'd2) r_opc <= writedata[15:0];
    end
  end

  // --------------------------------------------------------------------------
  // Status and result. A completion event wins over a same-cycle clear.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_result  <= 16'd0;
    end else begin
      if (w_done_hit || w_tmo_hit) begin
        r_done <= 1'b1;
      end else if (w_clear) begin
        r_done <= 1'b0;
      end

      if (w_tmo_hit) begin
        r_timeout <= 1'b1;
      end else if (w_clear) begin
        r_timeout <= 1'b0;
      end

      if (w_done_hit) begin
        r_result <= fma_result;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional interrupt
  // --------------------------------------------------------------------------
`ifdef FMA_CTRL_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      // irq_en is rewritten by every CTRL write, busy or not.
      if (w_wr_ctrl) begin
        r_irq_en <= writedata[2];
      end
      r_irq <= r_done && r_irq_en;
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Registered read path, refreshed every cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= 32'd0;
    end else begin
      case (address)
        3'd0:    r_readdata <= {16'd0, r_opa};
        3'd1:    r_readdata <= {16'd0, r_opb};
        3'd2:    r_readdata <= {16'd0, r_opc};
        3'd3:    r_readdata <= {28'd0, w_irq_en, r_timeout, r_done, w_busy};
        3'd4:    r_readdata <= {16'd0, r_result};
        default: r_readdata <= 32'd0;
      endcase
    end
  end

  assign readdata = r_readdata;
  assign fma_a    = r_opa;
  assign fma_b    = r_opb;
  assign fma_c    = r_opc;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_fma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_fma_ctrl
// Purpose  : Directed self-checking bench for soc_system_fma_ctrl with
//            TIMEOUT_CYCLES = 8. Read expectations go through a scoreboard
//            queue; direct port checks compare against bench constants.
//            Irq checks are compiled when FMA_CTRL_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_system_fma_ctrl;

  localparam int c_tmo = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [15:0] fma_a;
  logic [15:0] fma_b;
  logic [15:0] fma_c;
  logic        fma_start;
  logic        fma_done = 1'b0;
  logic [15:0] fma_result = 16'd0;
`ifdef FMA_CTRL_IRQ_EN
  logic        irq;
`endif

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  soc_system_fma_ctrl #(
    .TIMEOUT_CYCLES(c_tmo)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .fma_a     (fma_a),
    .fma_b     (fma_b),
    .fma_c     (fma_c),
    .fma_start (fma_start),
    .fma_done  (fma_done),
    .fma_result(fma_result)
`ifdef FMA_CTRL_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  // Each start pulse spans exactly one falling edge.
  always @(negedge clk) begin
    if (fma_start === 1'b1) start_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
    writedata = 32'd0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
    exp_t e;
    e.tag = tag;
    e.val = exp;
    sb_q.push_back(e);
    address = a;
    tick();
    e = sb_q.pop_front();
    chk(e.tag, readdata, e.val);
  endtask

  // Datapath model: after n idle cycles, present result r with fma_done.
  task automatic pulse_done(input int n, input logic [15:0] r);
    repeat (n) tick();
    fma_done   = 1'b1;
    fma_result = r;
    tick();
    fma_done   = 1'b0;
    fma_result = 16'd0;
  endtask

  // Counts cycles for which the status read shows busy, with a bound.
  task automatic poll_busy(output int cyc);
    address = 3'd3;
    cyc = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (readdata[0] === 1'b1) cyc++;
      else break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int busy_cyc;

    // ---------------- reset ----------------
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_fma_a", {16'd0, fma_a}, 32'd0);
    chk("rst_fma_start", {31'd0, fma_start}, 32'd0);
    rd_chk(3'd3, 32'd0, "rst_status");

    // ---------------- operands / register map ----------------
    wr(3'd0, 32'hABCD_0003);
    wr(3'd1, 32'h0000_0004);
    wr(3'd2, 32'h0000_0005);
    wr(3'd5, 32'hDEAD_BEEF);
    chk("op_fma_a", {16'd0, fma_a}, 32'h0003);
    chk("op_fma_b", {16'd0, fma_b}, 32'h0004);
    chk("op_fma_c", {16'd0, fma_c}, 32'h0005);
    rd_chk(3'd1, 32'h0000_0004, "rd_opb");
    rd_chk(3'd5, 32'd0, "rd_addr5");

    // ---------------- normal operation ----------------
    s0 = start_cnt;
    wr(3'd3, 32'h1);
    pulse_done(4, 16'h0011);
    rd_chk(3'd3, 32'h2, "norm_status");
    rd_chk(3'd4, 32'h11, "norm_result");
    chk("norm_starts", 32'(start_cnt - s0), 32'd1);

    // ---------------- busy protection ----------------
    s0 = start_cnt;
    wr(3'd3, 32'h1);
    tick();
    wr(3'd0, 32'h0000_FFFF);
    wr(3'd3, 32'h1);
    chk("busy_fma_a", {16'd0, fma_a}, 32'h0003);
    pulse_done(0, 16'h0022);
    rd_chk(3'd0, 32'h3, "busy_opa_rd");
    rd_chk(3'd3, 32'h2, "busy_status");
    rd_chk(3'd4, 32'h22, "busy_result");
    chk("busy_starts", 32'(start_cnt - s0), 32'd1);

    // ---------------- clear ----------------
    wr(3'd3, 32'h2);
    rd_chk(3'd3, 32'h0, "clr_status");

    // ---------------- timeout ----------------
    wr(3'd3, 32'h1);
    poll_busy(busy_cyc);
    chk("tmo_busy_cycles", 32'(busy_cyc), 32'(1 + c_tmo));
    chk("tmo_status", readdata, 32'h6);
    rd_chk(3'd4, 32'h22, "tmo_result");

    // ---------------- done on the timeout cycle ----------------
    wr(3'd3, 32'h1);
    pulse_done(c_tmo, 16'h0033);
    rd_chk(3'd3, 32'h2, "sim_status");
    rd_chk(3'd4, 32'h33, "sim_result");

    // ---------------- clear on the cycle done sets (min turnaround) ------
    wr(3'd3, 32'h1);
    tick();
    fma_done   = 1'b1;
    fma_result = 16'h0044;
    address    = 3'd3;
    writedata  = 32'h2;
    write      = 1'b1;
    tick();
    fma_done   = 1'b0;
    fma_result = 16'd0;
    write      = 1'b0;
    writedata  = 32'd0;
    rd_chk(3'd3, 32'h2, "clrrace_status");
    rd_chk(3'd4, 32'h44, "clrrace_result");
    wr(3'd3, 32'h2);
    rd_chk(3'd3, 32'h0, "clrrace_cleared");

    // ---------------- interrupt ----------------
`ifdef FMA_CTRL_IRQ_EN
    wr(3'd3, 32'h4);
    rd_chk(3'd3, 32'h8, "irq_en_status");
    chk("irq_idle", {31'd0, irq}, 32'd0);
    wr(3'd3, 32'h5);
    pulse_done(1, 16'h0055);
    chk("irq_at_done", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_rise", {31'd0, irq}, 32'd1);
    rd_chk(3'd3, 32'hA, "irq_status");
    wr(3'd3, 32'h6);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    tick();
    chk("irq_fall", {31'd0, irq}, 32'd0);
    wr(3'd3, 32'h1);
    pulse_done(1, 16'h0066);
    repeat (3) tick();
    chk("irq_disabled", {31'd0, irq}, 32'd0);
    rd_chk(3'd3, 32'h2, "irq_dis_status");
`else
    wr(3'd3, 32'h4);
    rd_chk(3'd3, 32'h0, "noirq_status");
`endif

    // ---------------- reset mid-WAIT ----------------
    wr(3'd3, 32'h1);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rstw_readdata", readdata, 32'd0);
    chk("rstw_fma_a", {16'd0, fma_a}, 32'd0);
    chk("rstw_fma_start", {31'd0, fma_start}, 32'd0);
    tick();
    reset = 1'b0;
    pulse_done(1, 16'h00AB);
    rd_chk(3'd3, 32'h0, "rstw_status");
    rd_chk(3'd4, 32'h0, "rstw_result");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/soc_system_fma_ctrl.md
# soc_system_fma_ctrl

Avalon-MM slave controller that sequences one external fused-multiply-add datapath on behalf of the HPS. Software writes three 16-bit operands and a start command. The block issues a single-cycle start to the datapath, waits for completion or timeout, and captures the result. Status and result are then available for readback. It sits beside the PIO slaves on the lightweight bridge, and its register read path has the same one-cycle registered read latency as those slaves.

## Interface
- TIMEOUT_CYCLES, 64 — maximum cycles spent in WAIT before timeout is declared; legal range 2..65535.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  register select (word address).
- write  in  1  write strobe, single-cycle, no waitrequest.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- fma_a / fma_b / fma_c  out  16 each  operand registers, driven continuously.
- fma_start  out  1  one-cycle start pulse to the datapath.
- fma_done  in  1  datapath completion; sampled only in WAIT.
- fma_result  in  16  datapath result; valid when fma_done is high.
- irq  out  1  interrupt; present only with FMA_CTRL_IRQ_EN.

## Operation
- Register map:
  - 0 OPA[15:0], RW.
  - 1 OPB[15:0], RW.
  - 2 OPC[15:0], RW.
  - 3 CTRL/STATUS:
    - Write bit0 = start, bit1 = clear done/timeout, bit2 = irq_en.
    - Read bit0 = busy, bit1 = done, bit2 = timeout, bit3 = irq_en.
  - 4 RESULT[15:0], RO.
  - 5–7 read 0; writes to them are ignored.
- Unused read bits are 0; unused write bits are ignored.
- Operand writes are accepted only when the FSM is IDLE; writes while busy are dropped.
- FSM states:
  - IDLE: a start write moves the FSM to ISSUE.
  - ISSUE: fma_start = 1 for exactly one cycle, clears the cycle counter, then moves to WAIT.
  - WAIT: the counter increments each cycle.
    - If fma_done = 1: RESULT <= fma_result, done <= 1, go to IDLE.
    - Else if counter == TIMEOUT_CYCLES-1: done <= 1, timeout <= 1, RESULT is unchanged, go to IDLE.
- fma_done has priority over timeout when both occur on the same cycle.
- busy = 1 in ISSUE and WAIT.
- A start while busy is ignored; no queueing.
- Start also clears done and timeout.
- Clear together with start in one write: clear is applied, then start.
- A done or timeout set wins over a simultaneous clear.
- The counter is 16 bits wide and never wraps, because TIMEOUT_CYCLES is at most 65535.

## Timing
- Reset values: all registers 0, readdata 0, fma_a/b/c 0, fma_start 0, irq 0, FSM in IDLE.
- Reset asserted mid-operation aborts immediately and returns everything to reset values. A late fma_done is then ignored.
- Read latency: readdata at edge E+1 reflects the register selected by address at edge E. readdata is updated every cycle regardless of any read strobe.
- Start sequence:
  - A start write sampled at edge E0 gives fma_start high from E0 to E1.
  - busy is visible in readdata from E1.
  - fma_done is first sampled at E2.
  - fma_done sampled high at Ek gives RESULT, done and busy = 0 visible in readdata at Ek+1.
- Minimum start-to-done turnaround: 3 cycles.
- fma_a/b/c hold stable from the start write until IDLE is re-entered.

## Configuration
- FMA_CTRL_IRQ_EN defined:
  - irq port exists.
  - irq = done & irq_en, registered; it rises one cycle after done sets.
  - irq falls one cycle after done is cleared or irq_en is cleared.
- Not defined:
  - No irq port.
  - CTRL bit2 is ignored on write, and status bit3 reads 0.

## Test plan
- Reset: assert reset mid-WAIT -> all outputs 0 and status reads 0x0; fma_done pulsed afterwards -> status stays 0x0.
- Normal op: write OPA=0x0003, OPB=0x0004, OPC=0x0005, start; model returns fma_result=0x0011 after 5 cycles -> exactly one fma_start pulse, status 0x2, RESULT 0x00000011.
- Timeout (TIMEOUT_CYCLES=8): start with no fma_done -> busy for 1+8 cycles, then status 0x6 and RESULT unchanged.
- Busy protection: during WAIT write OPA=0xFFFF and issue start -> fma_a unchanged and no second fma_start pulse; after completion OPA reads the old value.
- Simultaneous events: fma_done on the same cycle as counter == TIMEOUT_CYCLES-1 -> status 0x2; clear written on the cycle done sets -> done reads 1.
- IRQ (macro on): write irq_en, then start, then done -> irq high one cycle after done; write clear -> irq low one cycle later; same sequence with irq_en=0 -> irq stays 0.
